lcd12864_text_buffer: RTL and testbench



---
 rtl/lcd12864_pkg.sv | 17 +
 rtl/lcd12864_char_ram.sv | 42 ++++
 rtl/lcd12864_text_buffer.sv | 132 +++++++++++++
 tb/tb_lcd12864_text_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd12864_pkg.sv
// Shared constants for the LCD12864 display path (text buffer and controller).
package lcd12864_pkg;

    localparam int         LCD_LINES   = 2;
    localparam int         LCD_COLS    = 16;
    localparam logic [7:0] CHAR_BLANK  = 8'h20;

    // DDRAM base addresses of the two text lines, used by the controller
    localparam logic [7:0] DDRAM_LINE0 = 8'h80;
    localparam logic [7:0] DDRAM_LINE1 = 8'h90;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/lcd12864_char_ram.sv
// Character storage: one write port, registered read port, read-before-write.
// Indices past the end of the array read back as the fill character.
module lcd12864_char_ram #(
    parameter int         DEPTH  = 32,
    parameter int         ADDR_W = 5,
    parameter logic [7:0] FILL   = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [7:0] mem [DEPTH];
    logic       raddr_ok;

    assign raddr_ok = ({1'b0, raddr} < DEPTH_EXT);

    // Storage array, no reset so it maps onto LUT RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; old contents are returned when a write hits the same index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= FILL;
        end else if (raddr_ok) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= FILL;
        end
    end

endmodule

// File: rtl/lcd12864_text_buffer.sv
// 2x16 character frame buffer feeding the LCD12864 controller.
// Clears itself to blanks after reset or on request, accepts host writes
// while idle, and flags the controller when the contents need a refresh.
module lcd12864_text_buffer
    import lcd12864_pkg::*;
#(
    parameter int         LINES      = LCD_LINES,
    parameter int         COLS       = LCD_COLS,
    parameter int         ADDR_W     = 5,
    parameter logic [7:0] CLEAR_CHAR = CHAR_BLANK
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [7:0]        WR_DATA,
    input  logic              CLR_REQ,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [7:0]        RD_DATA,
    input  logic              FRAME_START,
    output logic              DIRTY,
    output logic              BUSY
);

    localparam int                DEPTH     = LINES * COLS;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy_q;
    logic              ready_q;
    logic              dirty_q;

    logic              wr_in_range;
    logic              wr_commit;
    logic              clr_last;
    logic              clr_done;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    assign wr_in_range = ({1'b0, WR_ADDR} < DEPTH_EXT);
    assign wr_commit   = WR_VALID & ready_q & wr_in_range;
    assign clr_last    = (clr_cnt == LAST_IDX);
    assign clr_done    = (state == ST_CLEAR) & clr_last & ~CLR_REQ;

    assign BUSY     = busy_q;
    assign WR_READY = ready_q;
    assign DIRTY    = dirty_q;

    // RAM write port: the clear sequence owns it, otherwise accepted host writes
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = WR_ADDR;
        ram_wdata = WR_DATA;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = CLEAR_CHAR;
        end else begin
            ram_we    = wr_commit;
        end
    end

    // Clear/idle sequencing with registered BUSY and WR_READY
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (CLR_REQ) begin
                        clr_cnt <= '0;
                    end else if (clr_last) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (CLR_REQ) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Refresh flag: content changes set it, FRAME_START clears it, set has priority
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            dirty_q <= 1'b0;
        end else if (wr_commit | clr_done) begin
            dirty_q <= 1'b1;
        end else if (FRAME_START) begin
            dirty_q <= 1'b0;
        end
    end

    lcd12864_char_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .FILL   (CLEAR_CHAR)
    ) u_char_ram (
        .clk   (SYS_CLK),
        .rst   (SYS_RST),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (RD_ADDR),
        .rdata (RD_DATA)
    );

endmodule

// File: tb/tb_lcd12864_text_buffer.sv
// Bench for lcd12864_text_buffer: directed scenarios with literal checks,
// plus a cycle-level model of the buffer compared on every falling edge.
module tb_lcd12864_text_buffer;

    localparam int         DEPTH = 32;
    localparam logic [7:0] BLANK = 8'h20;

    logic       SYS_CLK;
    logic       SYS_RST;
    logic       WR_VALID;
    logic       WR_READY;
    logic [4:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       CLR_REQ;
    logic [4:0] RD_ADDR;
    logic [7:0] RD_DATA;
    logic       FRAME_START;
    logic       DIRTY;
    logic       BUSY;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // model state
    logic [7:0] modelMem   [DEPTH];
    bit         modelKnown [DEPTH];
    int         clearLeft;
    bit         modelDirty;
    logic [7:0] expRd;
    bit         expRdKnown;

    lcd12864_text_buffer dut (
        .SYS_CLK     (SYS_CLK),
        .SYS_RST     (SYS_RST),
        .WR_VALID    (WR_VALID),
        .WR_READY    (WR_READY),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .CLR_REQ     (CLR_REQ),
        .RD_ADDR     (RD_ADDR),
        .RD_DATA     (RD_DATA),
        .FRAME_START (FRAME_START),
        .DIRTY       (DIRTY),
        .BUSY        (BUSY)
    );

    initial SYS_CLK = 1'b0;
    always #4 SYS_CLK = ~SYS_CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // drive one cycle of inputs at a falling edge, return at the next falling edge
    task automatic applyStimulus(input bit v, input logic [4:0] wa, input logic [7:0] wd,
                                 input bit clr, input logic [4:0] ra, input bit fs);
        WR_VALID    = v;
        WR_ADDR     = wa;
        WR_DATA     = wd;
        CLR_REQ     = clr;
        RD_ADDR     = ra;
        FRAME_START = fs;
        @(negedge SYS_CLK);
    endtask

    // Behavioural model: a clear is "clearLeft more blanking cycles"; writes only when not clearing
    always @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            clearLeft  = DEPTH;
            modelDirty = 1'b0;
            expRd      = BLANK;
            expRdKnown = 1'b1;
            for (int i = 0; i < DEPTH; i++) modelKnown[i] = 1'b0;
        end else begin
            bit clearing;
            bit setDirty;
            clearing = (clearLeft > 0);
            setDirty = 1'b0;
            expRd      = modelMem[RD_ADDR];
            expRdKnown = modelKnown[RD_ADDR];
            if (!clearing && WR_VALID) begin
                modelMem[WR_ADDR]   = WR_DATA;
                modelKnown[WR_ADDR] = 1'b1;
                setDirty = 1'b1;
            end
            if (clearing) begin
                modelMem[DEPTH - clearLeft]   = BLANK;
                modelKnown[DEPTH - clearLeft] = 1'b1;
                if (CLR_REQ) begin
                    clearLeft = DEPTH;
                end else begin
                    clearLeft = clearLeft - 1;
                    if (clearLeft == 0) setDirty = 1'b1;
                end
            end else if (CLR_REQ) begin
                clearLeft = DEPTH;
            end
            if (setDirty) modelDirty = 1'b1;
            else if (FRAME_START) modelDirty = 1'b0;
        end
    end

    // Compare DUT outputs against the model every falling edge
    always @(negedge SYS_CLK) begin
        if (checkEn) begin
            checkOutput("model_busy",  BUSY,     (clearLeft > 0) ? 1 : 0);
            checkOutput("model_ready", WR_READY, (clearLeft > 0) ? 0 : 1);
            checkOutput("model_dirty", DIRTY,    modelDirty ? 1 : 0);
            if (expRdKnown) checkOutput("model_rd_data", RD_DATA, expRd);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int busyCount;

        SYS_RST     = 1'b0;
        WR_VALID    = 1'b1;
        WR_ADDR     = 5'd0;
        WR_DATA     = 8'h55;
        CLR_REQ     = 1'b0;
        RD_ADDR     = 5'd0;
        FRAME_START = 1'b0;
        #2 SYS_RST = 1'b1;
        #1;
        checkEn = 1'b1;
        $display("[TB] reset values");
        checkOutput("rst_busy",  BUSY,     1);
        checkOutput("rst_ready", WR_READY, 0);
        checkOutput("rst_dirty", DIRTY,    0);
        checkOutput("rst_rd",    RD_DATA,  8'h20);
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        SYS_RST = 1'b0;

        // power-up clear with WR_VALID held high
        cycles = 0;
        do begin
            applyStimulus(1'b1, 5'd0, 8'h55, 1'b0, 5'd0, 1'b0);
            cycles++;
        end while (BUSY && cycles < 40);
        checkOutput("init_clear_len", cycles,   32);
        checkOutput("init_ready",     WR_READY, 1);
        checkOutput("init_dirty",     DIRTY,    1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'(i), 1'b0);
            checkOutput("init_blank", RD_DATA, 8'h20);
        end

        $display("[TB] host writes and readback");
        applyStimulus(1'b1, 5'd0,  8'h77, 1'b0, 5'd1, 1'b0);
        applyStimulus(1'b1, 5'd16, 8'h6B, 1'b0, 5'd1, 1'b0);
        applyStimulus(1'b0, 5'd0,  8'h00, 1'b0, 5'd0, 1'b0);
        checkOutput("rd_addr0",  RD_DATA, 8'h77);
        applyStimulus(1'b0, 5'd0,  8'h00, 1'b0, 5'd16, 1'b0);
        checkOutput("rd_addr16", RD_DATA, 8'h6B);
        checkOutput("dirty_after_write", DIRTY, 1);

        $display("[TB] frame start acknowledge");
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1);
        checkOutput("dirty_ack", DIRTY, 0);
        applyStimulus(1'b1, 5'd3, 8'h33, 1'b0, 5'd0, 1'b1);
        checkOutput("dirty_set_wins", DIRTY, 1);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd3, 1'b1);
        checkOutput("dirty_ack2", DIRTY, 0);
        checkOutput("rd_addr3",   RD_DATA, 8'h33);

        $display("[TB] read-before-write");
        applyStimulus(1'b1, 5'd5, 8'h2E, 1'b0, 5'd5, 1'b0);
        checkOutput("rbw_old", RD_DATA, 8'h20);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd5, 1'b0);
        checkOutput("rbw_new", RD_DATA, 8'h2E);

        $display("[TB] fill then restarted clear");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 5'(i), 8'h41, 1'b0, 5'd7, 1'b0);
        end
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd31, 1'b0);
        checkOutput("fill_rd", RD_DATA, 8'h41);
        busyCount = 0;
        for (int step = 0; step < 80; step++) begin
            applyStimulus(step > 0, 5'(step % 32), 8'h99, (step == 0) || (step == 10), 5'd31, 1'b0);
            if (BUSY) busyCount++;
            else break;
        end
        checkOutput("restart_busy_len", busyCount, 42);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'(i), 1'b0);
            checkOutput("restart_blank", RD_DATA, 8'h20);
        end

        $display("[TB] reset during clear");
        applyStimulus(1'b1, 5'd31, 8'h5A, 1'b0, 5'd31, 1'b0);
        applyStimulus(1'b0, 5'd0,  8'h00, 1'b0, 5'd31, 1'b0);
        applyStimulus(1'b0, 5'd0,  8'h00, 1'b1, 5'd31, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd31, 1'b0);
        checkOutput("pre_rst_rd",    RD_DATA, 8'h5A);
        checkOutput("pre_rst_dirty", DIRTY,   1);
        #2 SYS_RST = 1'b1;
        #1;
        checkOutput("async_busy",  BUSY,     1);
        checkOutput("async_ready", WR_READY, 0);
        checkOutput("async_dirty", DIRTY,    0);
        checkOutput("async_rd",    RD_DATA,  8'h20);
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        SYS_RST = 1'b0;
        cycles = 0;
        do begin
            applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0);
            cycles++;
        end while (BUSY && cycles < 40);
        checkOutput("rerun_clear_len", cycles, 32);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd31, 1'b0);
        checkOutput("rerun_addr31", RD_DATA, 8'h20);

        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0);
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
